// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline-stage register: word size and FSM state encodings.
package pipe_stage_reg_pkg;

  localparam int unsigned WORD_SIZE = 16;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry {ctrl, data, rd}: clock-enabled, async-reset register.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset (clears every field)
//   en_i                   load ctrl_i/data_i/rd_i on the rising edge
//   clr_i                  clear ctrl and rd only (wins over en_i); data is kept
//   ctrl_i, data_i, rd_i   entry payload in
//   ctrl_o, data_o, rd_o   stored entry
module pipe_entry_reg #(
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned DW     = 48,
  parameter int unsigned REG_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DW-1:0]     data_i,
  input  logic [REG_W-1:0]  rd_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DW-1:0]     data_o,
  output logic [REG_W-1:0]  rd_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DW-1:0]     data_q;
  logic [REG_W-1:0]  rd_q;

  // Clearing only ctrl/rd is enough to turn the entry into a harmless bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
      data_q <= '0;
      rd_q   <= '0;
    end else if (clr_i) begin
      ctrl_q <= '0;
      rd_q   <= '0;
    end else if (en_i) begin
      ctrl_q <= ctrl_i;
      data_q <= data_i;
      rd_q   <= rd_i;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;
  assign rd_o   = rd_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage latch with valid/ready flow control, optional skid entry,
// synchronous flush and bubble forcing.
// Ports:
//   Clk, Reset_N                   clock, async active-low reset
//   Flush                          synchronous flush, drops held and presented entries
//   In_Valid/In_Ready              upstream handshake
//   In_Ctrl, In_Data, In_Rd        upstream entry (data word 0 in LSBs)
//   Out_Valid/Out_Ready            downstream handshake
//   Out_Ctrl, Out_Data, Out_Rd     head entry (ctrl/rd are zero when Out_Valid=0)
//   Occupancy                      held entries, 0..2
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_W   = 3,
  parameter int unsigned DATA_W   = WORD_SIZE,
  parameter int unsigned NUM_DATA = 3,
  parameter int unsigned REG_W    = 2,
  parameter int unsigned SKID     = 1
) (
  input  logic                       Clk,
  input  logic                       Reset_N,
  input  logic                       Flush,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic [CTRL_W-1:0]          In_Ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] In_Data,
  input  logic [REG_W-1:0]           In_Rd,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [CTRL_W-1:0]          Out_Ctrl,
  output logic [NUM_DATA*DATA_W-1:0] Out_Data,
  output logic [REG_W-1:0]           Out_Rd,
  output logic [1:0]                 Occupancy
);

  localparam int unsigned DW = NUM_DATA * DATA_W;

  logic [1:0] state_q, state_d;
  logic       out_valid_q, out_valid_d;
  logic       in_ready_q, in_ready_d;
  logic       rst_done_q;

  logic accept, drain;
  logic main_en, main_clr, main_from_skid;
  logic skid_en, skid_clr;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DW-1:0]     main_data, skid_data, main_data_d;
  logic [REG_W-1:0]  main_rd, skid_rd, main_rd_d;

  // Skid mode: registered ready. Single-entry mode: ready whenever the head
  // leaves this cycle; rst_done_q holds ready low through reset.
  assign In_Ready = (SKID != 0) ? in_ready_q
                                : (rst_done_q & (~out_valid_q | Out_Ready));

  assign accept = In_Valid & In_Ready;
  assign drain  = out_valid_q & Out_Ready;

  // Next-state and entry-control decode.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    skid_clr       = 1'b0;
    if (Flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_en = 1'b1;
          end else if (accept) begin
            // Only reachable with the skid entry: head stalls, newcomer parks.
            state_d = ST_TWO;
            skid_en = 1'b1;
          end else if (drain) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d        = ST_ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign out_valid_d = (state_d != ST_EMPTY);
  assign in_ready_d  = (state_d != ST_TWO);

  // State and handshake flags.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      rst_done_q  <= 1'b1;
    end
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : In_Ctrl;
  assign main_data_d = main_from_skid ? skid_data : In_Data;
  assign main_rd_d   = main_from_skid ? skid_rd   : In_Rd;

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DW     (DW),
    .REG_W  (REG_W)
  ) u_main (
    .clk_i  (Clk),
    .rst_ni (Reset_N),
    .en_i   (main_en),
    .clr_i  (main_clr),
    .ctrl_i (main_ctrl_d),
    .data_i (main_data_d),
    .rd_i   (main_rd_d),
    .ctrl_o (main_ctrl),
    .data_o (main_data),
    .rd_o   (main_rd)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry_reg #(
      .CTRL_W (CTRL_W),
      .DW     (DW),
      .REG_W  (REG_W)
    ) u_skid (
      .clk_i  (Clk),
      .rst_ni (Reset_N),
      .en_i   (skid_en),
      .clr_i  (skid_clr),
      .ctrl_i (In_Ctrl),
      .data_i (In_Data),
      .rd_i   (In_Rd),
      .ctrl_o (skid_ctrl),
      .data_o (skid_data),
      .rd_o   (skid_rd)
    );
  end else begin : g_no_skid
    assign skid_ctrl = '0;
    assign skid_data = '0;
    assign skid_rd   = '0;
  end

  // Head ctrl/rd are cleared on every transition to EMPTY, so bubbles are zero.
  assign Out_Valid = out_valid_q;
  assign Out_Ctrl  = main_ctrl;
  assign Out_Data  = main_data;
  assign Out_Rd    = main_rd;
  assign Occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: one skid-mode instance and one
// single-entry instance, each with its own expected-entry queue.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 3;
  localparam int unsigned DW = 48;
  localparam int unsigned RW = 2;
  localparam int unsigned EW = CW + DW + RW;
  typedef logic [EW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Skid-mode instance signals
  logic          flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [CW-1:0] in_ctrl1 = '0;
  logic [DW-1:0] in_data1 = '0;
  logic [RW-1:0] in_rd1 = '0;
  logic          in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl1;
  logic [DW-1:0] out_data1;
  logic [RW-1:0] out_rd1;
  logic [1:0]    occ1;

  // Single-entry instance signals
  logic          flush0 = 1'b0, in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [CW-1:0] in_ctrl0 = '0;
  logic [DW-1:0] in_data0 = '0;
  logic [RW-1:0] in_rd0 = '0;
  logic          in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl0;
  logic [DW-1:0] out_data0;
  logic [RW-1:0] out_rd0;
  logic [1:0]    occ0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(16), .NUM_DATA(3), .REG_W(RW), .SKID(1)) dut1 (
    .Clk(clk), .Reset_N(rst_n), .Flush(flush1),
    .In_Valid(in_valid1), .In_Ready(in_ready1),
    .In_Ctrl(in_ctrl1), .In_Data(in_data1), .In_Rd(in_rd1),
    .Out_Valid(out_valid1), .Out_Ready(out_ready1),
    .Out_Ctrl(out_ctrl1), .Out_Data(out_data1), .Out_Rd(out_rd1),
    .Occupancy(occ1)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(16), .NUM_DATA(3), .REG_W(RW), .SKID(0)) dut0 (
    .Clk(clk), .Reset_N(rst_n), .Flush(flush0),
    .In_Valid(in_valid0), .In_Ready(in_ready0),
    .In_Ctrl(in_ctrl0), .In_Data(in_data0), .In_Rd(in_rd0),
    .Out_Valid(out_valid0), .Out_Ready(out_ready0),
    .Out_Ctrl(out_ctrl0), .Out_Data(out_data0), .Out_Rd(out_rd0),
    .Occupancy(occ0)
  );

  int vectors = 0;
  int errors  = 0;

  ent_t q1[$];
  ent_t q0[$];

  // Results of the last tick
  bit   t_acc1, t_got1, t_acc0, t_got0;
  ent_t t_obs1, t_obs0;
  ent_t exp_e;

  // Advance one clock: record accepted entries into the queues and capture
  // drained heads. Entered and left #1 after a rising edge.
  task automatic tick();
    #1;
    t_acc1 = in_valid1 && in_ready1 && !flush1;
    t_got1 = out_valid1 && out_ready1 && !flush1;
    t_obs1 = {out_ctrl1, out_data1, out_rd1};
    if (flush1) q1.delete();
    if (t_acc1) q1.push_back({in_ctrl1, in_data1, in_rd1});
    t_acc0 = in_valid0 && in_ready0 && !flush0;
    t_got0 = out_valid0 && out_ready0 && !flush0;
    t_obs0 = {out_ctrl0, out_data0, out_rd0};
    if (flush0) q0.delete();
    if (t_acc0) q0.push_back({in_ctrl0, in_data0, in_rd0});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid1, out_ctrl1, out_data1, out_rd1, occ1, in_ready1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b c=%h d=%h rd=%h occ=%0d rdy=%b, expected all 0",
               out_valid1, out_ctrl1, out_data1, out_rd1, occ1, in_ready1);
    end
    vectors++;
    if ({out_valid0, in_ready0, occ0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs0: got v=%b rdy=%b occ=%0d, expected 0", out_valid0, in_ready0, occ0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready1 !== 1'b0 || in_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b/%b, expected 0/0", in_ready1, in_ready0);
    end
    @(posedge clk); #1;
    vectors++;
    if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b/%b, expected 1/1", in_ready1, in_ready0);
    end
  endtask

  task automatic test_streaming();
    out_ready1 = 1'b1;
    in_ctrl1   = 3'b101;
    for (int i = 1; i <= 8; i++) begin
      in_valid1 = 1'b1;
      in_data1  = {16'(i), 16'h0000, 16'(16'h1000 + 16'(i))};
      in_rd1    = 2'(i);
      tick();
      vectors++;
      if (!t_acc1) begin
        errors++;
        $display("FAIL stream_accept: entry %0d not accepted (In_Ready=%b), expected accepted", i, in_ready1);
      end
      if (i > 1) begin
        vectors++;
        if (!t_got1) begin
          errors++;
          $display("FAIL stream_gap: no output at step %0d, expected one", i);
        end else begin
          exp_e = (q1.size() != 0) ? q1.pop_front() : 'x;
          if (t_obs1 !== exp_e) begin
            errors++;
            $display("FAIL stream_data: got %h expected %h", t_obs1, exp_e);
          end
        end
      end
    end
    in_valid1 = 1'b0;
    tick();
    vectors++;
    exp_e = (q1.size() != 0) ? q1.pop_front() : 'x;
    if (!t_got1 || t_obs1 !== exp_e) begin
      errors++;
      $display("FAIL stream_last: got v=%b %h expected %h", t_got1, t_obs1, exp_e);
    end
    vectors++;
    if (out_valid1 !== 1'b0 || occ1 !== 2'd0) begin
      errors++;
      $display("FAIL stream_empty: got v=%b occ=%0d expected 0/0", out_valid1, occ1);
    end
  endtask

  task automatic test_backpressure();
    int drained = 0;
    out_ready1 = 1'b0;
    in_ctrl1   = 3'b010;
    in_rd1     = 2'd1;
    for (int i = 1; i <= 2; i++) begin
      in_valid1 = 1'b1;
      in_data1  = {16'(16'h00A0 + 16'(i)), 16'h0000, 16'h2000};
      tick();
      vectors++;
      if (!t_acc1) begin
        errors++;
        $display("FAIL bp_accept: A%0d not accepted, expected accepted", i);
      end
    end
    vectors++;
    if (occ1 !== 2'd2 || in_ready1 !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got occ=%0d rdy=%b expected 2/0", occ1, in_ready1);
    end
    in_data1 = {16'h00A3, 16'h0000, 16'h2000};
    tick();
    vectors++;
    if (t_acc1 || t_got1) begin
      errors++;
      $display("FAIL bp_hold: got acc=%b out=%b expected 0/0", t_acc1, t_got1);
    end
    out_ready1 = 1'b1;
    for (int k = 0; k < 10 && (q1.size() != 0 || in_valid1); k++) begin
      tick();
      if (t_acc1) in_valid1 = 1'b0;
      if (t_got1) begin
        drained++;
        vectors++;
        exp_e = (q1.size() != 0) ? q1.pop_front() : 'x;
        if (t_obs1 !== exp_e) begin
          errors++;
          $display("FAIL bp_order: got %h expected %h", t_obs1, exp_e);
        end
      end
    end
    vectors++;
    if (drained != 3 || q1.size() != 0 || in_valid1) begin
      errors++;
      $display("FAIL bp_count: drained %0d left %0d pending %b, expected 3/0/0", drained, q1.size(), in_valid1);
    end
  endtask

  task automatic test_flush();
    out_ready1 = 1'b0;
    in_ctrl1   = 3'b110;
    in_rd1     = 2'd2;
    for (int i = 1; i <= 2; i++) begin
      in_valid1 = 1'b1;
      in_data1  = {16'(16'h00B0 + 16'(i)), 16'h0000, 16'h3000};
      tick();
    end
    vectors++;
    if (occ1 !== 2'd2) begin
      errors++;
      $display("FAIL flush_setup: got occ=%0d expected 2", occ1);
    end
    // Flush from TWO with a new input and downstream ready
    flush1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b1;
    in_data1 = {16'h00FF, 16'h0000, 16'h3000};
    tick();
    flush1 = 1'b0; in_valid1 = 1'b0;
    vectors++;
    if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || out_ctrl1 !== '0 || out_rd1 !== '0) begin
      errors++;
      $display("FAIL flush_two: got occ=%0d v=%b c=%h rd=%h expected 0/0/0/0", occ1, out_valid1, out_ctrl1, out_rd1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (t_got1 || out_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak: got out=%b %h, expected no output", t_got1, t_obs1);
      end
    end
    // Flush from ONE while the input would otherwise be accepted
    out_ready1 = 1'b0; in_valid1 = 1'b1;
    in_data1 = {16'h00C1, 16'h0000, 16'h3000};
    tick();
    flush1 = 1'b1;
    in_data1 = {16'h00FF, 16'h0000, 16'h3000};
    tick();
    flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
    vectors++;
    if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || out_ctrl1 !== '0) begin
      errors++;
      $display("FAIL flush_one: got occ=%0d v=%b c=%h expected 0/0/0", occ1, out_valid1, out_ctrl1);
    end
    tick();
    vectors++;
    if (t_got1) begin
      errors++;
      $display("FAIL flush_one_leak: got %h expected no output", t_obs1);
    end
  endtask

  task automatic test_skid0();
    out_ready0 = 1'b0;
    in_ctrl0   = 3'b011;
    in_rd0     = 2'd2;
    in_valid0  = 1'b1;
    in_data0   = {16'h0D01, 16'h0000, 16'h4000};
    tick();
    vectors++;
    if (!t_acc0) begin
      errors++;
      $display("FAIL s0_first: D1 not accepted, expected accepted");
    end
    in_data0 = {16'h0D02, 16'h0000, 16'h4000};
    #1;
    vectors++;
    if (in_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL s0_stall_ready: got %b expected 0", in_ready0);
    end
    tick();
    vectors++;
    if (t_acc0 || t_got0 || occ0 !== 2'd1) begin
      errors++;
      $display("FAIL s0_hold: got acc=%b out=%b occ=%0d expected 0/0/1", t_acc0, t_got0, occ0);
    end
    out_ready0 = 1'b1;
    #1;
    vectors++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL s0_comb_ready: got %b expected 1", in_ready0);
    end
    for (int i = 2; i <= 6; i++) begin
      in_data0 = {16'(16'h0D00 + 16'(i)), 16'h0000, 16'h4000};
      tick();
      vectors++;
      exp_e = (q0.size() != 0) ? q0.pop_front() : 'x;
      if (!t_acc0 || !t_got0 || t_obs0 !== exp_e) begin
        errors++;
        $display("FAIL s0_stream: acc=%b out=%b got %h expected %h", t_acc0, t_got0, t_obs0, exp_e);
      end
    end
    in_valid0 = 1'b0;
    tick();
    vectors++;
    exp_e = (q0.size() != 0) ? q0.pop_front() : 'x;
    if (!t_got0 || t_obs0 !== exp_e || out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL s0_last: out=%b got %h expected %h, v=%b", t_got0, t_obs0, exp_e, out_valid0);
    end
  endtask

  task automatic test_bubble();
    out_ready1 = 1'b1;
    in_ctrl1   = 3'b111;
    in_rd1     = 2'd3;
    in_valid1  = 1'b1;
    in_data1   = {16'h0E01, 16'h0000, 16'h5000};
    tick();
    in_valid1 = 1'b0;
    vectors++;
    if (out_valid1 !== 1'b1 || out_ctrl1 !== 3'b111) begin
      errors++;
      $display("FAIL bubble_e1: got v=%b c=%h expected 1/7", out_valid1, out_ctrl1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) begin
        vectors++;
        exp_e = (q1.size() != 0) ? q1.pop_front() : 'x;
        if (!t_got1 || t_obs1 !== exp_e) begin
          errors++;
          $display("FAIL bubble_e1_data: got %h expected %h", t_obs1, exp_e);
        end
      end
      vectors++;
      if (out_valid1 !== 1'b0 || out_ctrl1 !== '0 || out_rd1 !== '0) begin
        errors++;
        $display("FAIL bubble_gap: cycle %0d got v=%b c=%h rd=%h expected 0/0/0", k, out_valid1, out_ctrl1, out_rd1);
      end
    end
    in_valid1 = 1'b1;
    in_data1  = {16'h0E02, 16'h0000, 16'h5000};
    tick();
    in_valid1 = 1'b0;
    vectors++;
    if (out_valid1 !== 1'b1 || out_ctrl1 !== 3'b111 || out_rd1 !== 2'd3) begin
      errors++;
      $display("FAIL bubble_e2: got v=%b c=%h rd=%h expected 1/7/3", out_valid1, out_ctrl1, out_rd1);
    end
    tick();
    vectors++;
    exp_e = (q1.size() != 0) ? q1.pop_front() : 'x;
    if (!t_got1 || t_obs1 !== exp_e) begin
      errors++;
      $display("FAIL bubble_e2_data: got %h expected %h", t_obs1, exp_e);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready1 = 1'b0;
    in_ctrl1   = 3'b001;
    in_rd1     = 2'd1;
    for (int i = 1; i <= 2; i++) begin
      in_valid1 = 1'b1;
      in_data1  = {16'(16'h0F00 + 16'(i)), 16'h1111, 16'h6000};
      tick();
    end
    vectors++;
    if (occ1 !== 2'd2) begin
      errors++;
      $display("FAIL midrst_setup: got occ=%0d expected 2", occ1);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid1, out_ctrl1, out_data1, out_rd1, occ1, in_ready1} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got v=%b c=%h d=%h rd=%h occ=%0d rdy=%b expected all 0",
               out_valid1, out_ctrl1, out_data1, out_rd1, occ1, in_ready1);
    end
    q1.delete();
    q0.delete();
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || occ1 !== 2'd0) begin
      errors++;
      $display("FAIL midrst_release: got rdy=%b v=%b occ=%0d expected 1/0/0", in_ready1, out_valid1, occ1);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0();
    test_bubble();
    test_reset_midstream();
    vectors++;
    if (q1.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL leftover: queues hold %0d/%0d entries, expected 0/0", q1.size(), q0.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
